// File: rtl/alu_writeback.sv
// alu_writeback
//   Writeback stage behind the ALU. It accepts one result bundle per
//   handshake and commits it to the single register-file write port. A
//   bundle that carries a second result (MUL high word, DIV remainder)
//   takes two cycles to commit. The stage also holds the architectural
//   flag register and counts retired bundles.
//
// Ports
//   clk, rst          clock and asynchronous active-high reset
//   in_valid/in_ready bundle handshake (accept on valid && ready)
//   write_en[1:0]     bit0 writes result_0, bit1 writes result_1
//   flag_we, flag_in  optional flag-register commit
//   dest_0/dest_1     register indices for result_0/result_1
//   result_0/result_1 ALU results
//   rf_we/rf_waddr/rf_wdata  register-file write port (also the forwarding view)
//   flag_reg          committed flags
//   busy              high while a bundle is being committed
//   commit_count      retired bundles, wraps at 2^16
module alu_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        write_en,
  input  logic              flag_we,
  input  logic [ADDR_W-1:0] dest_0,
  input  logic [ADDR_W-1:0] dest_1,
  input  logic [DATA_W-1:0] result_0,
  input  logic [DATA_W-1:0] result_1,
  input  logic [DATA_W-1:0] flag_in,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] flag_reg,
  output logic              busy,
  output logic [15:0]       commit_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Holding registers for the accepted bundle
  logic [1:0]        we_q;
  logic              flag_we_q;
  logic [ADDR_W-1:0] dest_0_q, dest_1_q;
  logic [DATA_W-1:0] result_0_q, result_1_q, flag_in_q;

  logic [DATA_W-1:0] flag_reg_q, flag_reg_d;
  logic [15:0]       commit_count_q, commit_count_d;

  logic accept;

  assign accept = in_valid && in_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A new bundle always starts in WR0; in_ready already
  // excludes the one case (WR0 of a dual-write bundle) where that is illegal.
  always_comb begin
    state_d = IDLE;
    if (accept) begin
      state_d = WR0;
    end else if (state_q == WR0 && we_q[1]) begin
      state_d = WR1;
    end
  end

  // Output logic
  always_comb begin
    in_ready = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = dest_0_q;
    rf_wdata = result_0_q;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        // Keep showing whichever write was issued last.
        if (we_q[1]) begin
          rf_waddr = dest_1_q;
          rf_wdata = result_1_q;
        end
      end
      WR0: begin
        in_ready = ~we_q[1];
        rf_we    = we_q[0];
      end
      WR1: begin
        in_ready = 1'b1;
        rf_we    = 1'b1;
        rf_waddr = dest_1_q;
        rf_wdata = result_1_q;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Flags and retire count commit once per bundle, at the end of WR0,
  // regardless of which results the bundle writes.
  always_comb begin
    flag_reg_d     = flag_reg_q;
    commit_count_d = commit_count_q;
    if (state_q == WR0) begin
      commit_count_d = commit_count_q + 16'd1;
      if (flag_we_q) begin
        flag_reg_d = flag_in_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q           <= '0;
      flag_we_q      <= 1'b0;
      dest_0_q       <= '0;
      dest_1_q       <= '0;
      result_0_q     <= '0;
      result_1_q     <= '0;
      flag_in_q      <= '0;
      flag_reg_q     <= '0;
      commit_count_q <= '0;
    end else begin
      flag_reg_q     <= flag_reg_d;
      commit_count_q <= commit_count_d;
      if (accept) begin
        we_q       <= write_en;
        flag_we_q  <= flag_we;
        dest_0_q   <= dest_0;
        dest_1_q   <= dest_1;
        result_0_q <= result_0;
        result_1_q <= result_1;
        flag_in_q  <= flag_in;
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign flag_reg     = flag_reg_q;
  assign commit_count = commit_count_q;

endmodule

// File: tb/tb_alu_writeback.sv
`timescale 1ns/1ps
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  write_en = 2'b00;
  logic        flag_we = 1'b0;
  logic [3:0]  dest_0 = '0, dest_1 = '0;
  logic [15:0] result_0 = '0, result_1 = '0, flag_in = '0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [15:0] flag_reg;
  logic        busy;
  logic [15:0] commit_count;

  alu_writeback #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .write_en(write_en), .flag_we(flag_we),
    .dest_0(dest_0), .dest_1(dest_1),
    .result_0(result_0), .result_1(result_1), .flag_in(flag_in),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flag_reg(flag_reg), .busy(busy), .commit_count(commit_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted bundle becomes a list of write-port cycles ("slots").
  // The head slot is what the port shows this cycle; a new bundle can be
  // taken whenever at most the current slot is still outstanding.
  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [15:0] data;
    logic        primary;
    logic        fwe;
    logic [15:0] flag;
  } slot_t;

  slot_t       slots[$];
  logic [15:0] m_flag  = '0;
  logic [15:0] m_count = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      slots.delete();
      m_flag  = '0;
      m_count = '0;
    end else begin
      bit    acc;
      slot_t s;
      acc = in_valid && (slots.size() <= 1);
      if (slots.size() > 0) begin
        s = slots.pop_front();
        if (s.primary) begin
          m_count = m_count + 16'd1;
          if (s.fwe) m_flag = s.flag;
        end
      end
      if (acc) begin
        slots.push_back('{we: write_en[0], addr: dest_0, data: result_0,
                          primary: 1'b1, fwe: flag_we, flag: flag_in});
        if (write_en[1])
          slots.push_back('{we: 1'b1, addr: dest_1, data: result_1,
                            primary: 1'b0, fwe: 1'b0, flag: 16'h0});
      end
    end
  end

  // Observed register-file writes, for the hand-computed checks.
  logic [19:0] wlog[$];

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic exp_we;
    exp_we = (slots.size() > 0) ? slots[0].we : 1'b0;
    chk("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
    chk("busy", {31'd0, busy}, {31'd0, slots.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, slots.size() <= 1});
    chk("flag_reg", {16'd0, flag_reg}, {16'd0, m_flag});
    chk("commit_count", {16'd0, commit_count}, {16'd0, m_count});
    if (exp_we) begin
      chk("rf_waddr", {28'd0, rf_waddr}, {28'd0, slots[0].addr});
      chk("rf_wdata", {16'd0, rf_wdata}, {16'd0, slots[0].data});
    end
    if (!rst && rf_we) wlog.push_back({rf_waddr, rf_wdata});
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [1:0] we, input logic fwe, input logic [3:0] d0,
                      input logic [3:0] d1, input logic [15:0] r0, input logic [15:0] r1,
                      input logic [15:0] f);
    int n;
    bit ok;
    write_en = we; flag_we = fwe; dest_0 = d0; dest_1 = d1;
    result_0 = r0; result_1 = r1; flag_in = f; in_valid = 1'b1;
    n = 0; ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      n_total++;
      $display("FAIL send_timeout: in_ready stayed 0 for 20 cycles, required 1");
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    wlog.delete();
  endtask

  task automatic chk_wr(input string name, input int idx, input logic [3:0] a, input logic [15:0] d);
    if (idx < wlog.size()) chk(name, {12'd0, wlog[idx]}, {12'd0, a, d});
  endtask

  initial begin
    // Reset state
    #2;
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_count", {16'd0, commit_count}, 32'd0);
    chk("reset_waddr", {28'd0, rf_waddr}, 32'd0);
    do_reset();
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Single ADD
    send(2'b01, 1'b1, 4'd3, 4'd0, 16'h1234, 16'h0, 16'h0020);
    @(negedge clk);
    chk("add_we", {31'd0, rf_we}, 32'd1);
    chk("add_waddr", {28'd0, rf_waddr}, 32'd3);
    chk("add_wdata", {16'd0, rf_wdata}, 32'h1234);
    @(posedge clk); #1;
    chk("add_flag", {16'd0, flag_reg}, 32'h0020);
    chk("add_count", {16'd0, commit_count}, 32'd1);
    chk("add_busy_after", {31'd0, busy}, 32'd0);
    wait_cycles(2);

    // MUL followed at once by ADD
    do_reset();
    send(2'b11, 1'b0, 4'd4, 4'd5, 16'hC000, 16'h0001, 16'h0);
    send(2'b01, 1'b0, 4'd6, 4'd0, 16'h0BEE, 16'h0, 16'h0);
    wait_cycles(3);
    chk("mul_nwrites", wlog.size(), 32'd3);
    chk_wr("mul_w0", 0, 4'd4, 16'hC000);
    chk_wr("mul_w1", 1, 4'd5, 16'h0001);
    chk_wr("mul_w2", 2, 4'd6, 16'h0BEE);
    chk("mul_count", {16'd0, commit_count}, 32'd2);

    // Four back-to-back single writes
    do_reset();
    for (int i = 1; i <= 4; i++)
      send(2'b01, 1'b0, 4'(i), 4'd0, 16'(16'hA0 + i), 16'h0, 16'h0);
    wait_cycles(3);
    chk("b2b_nwrites", wlog.size(), 32'd4);
    for (int i = 1; i <= 4; i++)
      chk_wr($sformatf("b2b_w%0d", i), i - 1, 4'(i), 16'(16'hA0 + i));
    chk("b2b_count", {16'd0, commit_count}, 32'd4);

    // write_en=10: no primary write, secondary written, flags/count commit
    do_reset();
    send(2'b10, 1'b1, 4'd1, 4'd9, 16'h1111, 16'h9999, 16'h0004);
    wait_cycles(3);
    chk("we10_nwrites", wlog.size(), 32'd1);
    chk_wr("we10_w0", 0, 4'd9, 16'h9999);
    chk("we10_flag", {16'd0, flag_reg}, 32'h0004);

    // Same destination, both writes in order
    do_reset();
    send(2'b11, 1'b0, 4'd7, 4'd7, 16'h0AAA, 16'h0BBB, 16'h0);
    wait_cycles(3);
    chk("same_nwrites", wlog.size(), 32'd2);
    chk_wr("same_w0", 0, 4'd7, 16'h0AAA);
    chk_wr("same_w1", 1, 4'd7, 16'h0BBB);

    // CMP: no write, flags and count commit
    do_reset();
    send(2'b00, 1'b1, 4'd2, 4'd0, 16'hFFFF, 16'h0, 16'h0008);
    wait_cycles(3);
    chk("cmp_nwrites", wlog.size(), 32'd0);
    chk("cmp_flag", {16'd0, flag_reg}, 32'h0008);
    chk("cmp_count", {16'd0, commit_count}, 32'd1);

    // flag_we=0 leaves the flag register alone
    do_reset();
    send(2'b01, 1'b1, 4'd1, 4'd0, 16'h0001, 16'h0, 16'h0080);
    send(2'b01, 1'b0, 4'd2, 4'd0, 16'h0002, 16'h0, 16'h5555);
    wait_cycles(3);
    chk("nofl_flag", {16'd0, flag_reg}, 32'h0080);
    chk("nofl_nwrites", wlog.size(), 32'd2);
    chk_wr("nofl_w1", 1, 4'd2, 16'h0002);

    // Asynchronous reset in the middle of WR0 of a dual-write bundle
    send(2'b11, 1'b1, 4'd6, 4'd7, 16'h6666, 16'h7777, 16'h0F0F);
    rst = 1'b1;
    wlog.delete();
    #1;
    chk("arst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("arst_flag", {16'd0, flag_reg}, 32'd0);
    chk("arst_count", {16'd0, commit_count}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    wait_cycles(2);
    rst = 1'b0;
    #1;
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    wait_cycles(2);
    chk("arst_nwrites", wlog.size(), 32'd0);
    send(2'b01, 1'b1, 4'd8, 4'd0, 16'h8888, 16'h0, 16'h0001);
    wait_cycles(2);
    chk("arst_post_nwrites", wlog.size(), 32'd1);
    chk_wr("arst_post_w0", 0, 4'd8, 16'h8888);
    chk("arst_post_count", {16'd0, commit_count}, 32'd1);
    chk("arst_post_flag", {16'd0, flag_reg}, 32'h0001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
